// File: rtl/fifo_data_send_if.sv
// FIFO read port plus outgoing start/byte/bit link for fifo_data_send.
// The master side is the sender; the slave side is the FIFO plus the link sink.
interface fifo_data_send_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              tx_start;
  logic              tx_byte;
  logic              tx_data;

  modport master (
    input  fifo_empty, fifo_data,
    output fifo_rd_en, tx_start, tx_byte, tx_data
  );

  modport slave (
    output fifo_empty, fifo_data,
    input  fifo_rd_en, tx_start, tx_byte, tx_data
  );
endinterface

// File: rtl/fifo_data_send.sv
// Pops bytes from a registered-read FIFO and serialises them as framed bursts:
// tx_start, then up to MAX_BURST back-to-back bytes on tx_byte/tx_data, then done.
module fifo_data_send #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  send_en,
  fifo_data_send_if.master      bus,
  output logic                  busy,
  output logic                  done
);

  // The continuation pop is decided at bit DATA_W-3, so bytes need at least 3 bits.
  localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   CHECK_BIT = CNT_W'(DATA_W - 3);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_START,
    S_SHIFT,
    S_END
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shifted;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [BURST_W-1:0]  burst_cnt_q;
  logic                cont_q;
  logic                cont_ok;
  logic                rd_en_q, rd_en_d;

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    rd_en_d      = 1'b0;
    cont_ok      = 1'b0;
    shifted      = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};
    bus.tx_start = (state_q == S_START);
    bus.tx_byte  = (state_q == S_SHIFT);
    bus.tx_data  = (state_q == S_SHIFT) && (MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0]);
    bus.fifo_rd_en = rd_en_q;
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_END);

    case (state_q)
      S_IDLE: begin
        if (send_en && !bus.fifo_empty) begin
          state_d = S_FETCH;
          rd_en_d = 1'b1;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_START;
      S_START: state_d = S_SHIFT;
      S_SHIFT: begin
        // Committing three bits early lets the registered pop land its data
        // exactly on the last bit, so the next byte follows without a gap.
        if (bit_cnt_q == CHECK_BIT && send_en && !bus.fifo_empty &&
            burst_cnt_q < BURST_MAX) begin
          cont_ok = 1'b1;
          rd_en_d = 1'b1;
        end
        if (bit_cnt_q == LAST_BIT && !cont_q) begin
          state_d = S_END;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      burst_cnt_q <= '0;
      cont_q      <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      case (state_q)
        S_WAIT: begin
          shift_q     <= bus.fifo_data;
          burst_cnt_q <= BURST_W'(1);
          bit_cnt_q   <= '0;
        end
        S_SHIFT: begin
          if (cont_ok) begin
            cont_q <= 1'b1;
          end
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q <= '0;
            cont_q    <= 1'b0;
            if (cont_q) begin
              shift_q     <= bus.fifo_data;
              burst_cnt_q <= burst_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            shift_q   <= shifted;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fifo_data_send.md
Name: fifo_data_send

Overview:
- Transmit-side counterpart of the byte-framing receiver that loads the FIFO: reads bytes out of a FIFO and sends them as a serial frame on a start/byte/bit interface.
- Each burst is up to MAX_BURST back-to-back bytes. A one-cycle tx_start precedes the first byte, and tx_byte brackets every bit-cycle.
- Sits between the FIFO read port (rd_en/data_o/empty) and the outgoing link.

Parameters:
- DATA_W, 8, byte width; the bit counter is sized log2(DATA_W).
- MAX_BURST, 16, maximum number of bytes per frame (at least 1).
- MSB_FIRST, 1, 1 sends bit DATA_W-1 first; 0 sends bit 0 first.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- send_en  in  1  permission to start or continue sending.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_W  FIFO read data; valid the cycle after fifo_rd_en=1 (registered read).
- fifo_rd_en  out  1  registered one-cycle FIFO pop pulse.
- tx_start  out  1  one-cycle frame-start marker.
- tx_byte  out  1  high on every cycle that carries a data bit.
- tx_data  out  1  serial data bit; 0 when tx_byte=0.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Clock and reset: one clock (clk). reset_n is synchronous and active-low.
- Reset (reset_n=0 at an edge):
  - State goes to IDLE. All outputs are 0; shift register, bit_cnt and burst_cnt are cleared.
  - Applies mid-frame too. A fifo_data word already popped but not yet sent is discarded. No done pulse.
- IDLE:
  - If send_en=1 and fifo_empty=0, go to FETCH.
- FETCH, 1 cycle:
  - fifo_rd_en=1. Go to WAIT.
- WAIT, 1 cycle:
  - fifo_data is valid; capture it into the shift register at the end of the cycle.
  - Set burst_cnt=1. Go to START.
- START, 1 cycle:
  - tx_start=1, tx_byte=0. Go to SHIFT with bit_cnt=0.
- SHIFT, DATA_W cycles per byte:
  - tx_byte=1; tx_data is the current bit per MSB_FIRST.
  - bit_cnt increments each cycle and wraps from DATA_W-1 to 0.
- Continuation check, evaluated at bit_cnt=DATA_W-3:
  - Condition: send_en=1, fifo_empty=0, burst_cnt<MAX_BURST.
  - If met: fifo_rd_en=1 at bit_cnt=DATA_W-2, and fifo_data is captured into the shift register at the end of bit_cnt=DATA_W-1.
  - burst_cnt then increments and SHIFT continues with no gap and no tx_start.
- End of frame:
  - If the condition is not met, leave SHIFT after bit_cnt=DATA_W-1 and go to END.
  - END, 1 cycle: done=1, tx_byte=0. Go to IDLE.
  - A new frame needs at least 1 IDLE cycle after END.
- Latency:
  - IDLE with data present → tx_start after 3 cycles (FETCH, WAIT, START).
  - First data bit 4 cycles after leaving IDLE.
  - Frame length in cycles = 2 + 1 + N·DATA_W + 1.
- Boundary conditions:
  - send_en falling mid-byte: the current byte completes. Only the continuation check sees send_en.
  - fifo_empty rising after the pop decision has no effect: the word is already committed.
  - Never pop when fifo_empty=1. fifo_rd_en is never high for 2 consecutive cycles.
  - At burst_cnt=MAX_BURST, the frame ends even if the FIFO is non-empty; the next frame starts from IDLE.
  - MAX_BURST=1 gives one byte per frame.
  - A continuation pop and a new frame can never coincide.

Test Plan:
- Single byte, MSB_FIRST=1: FIFO holds 8'hA5, send_en=1 → fifo_rd_en pulses once, tx_start one cycle, then tx_data=1,0,1,0,0,1,0,1 with tx_byte=1 for 8 cycles, then done one cycle. Total 12 cycles; busy=1 throughout.
- Back-to-back: FIFO holds 8'h01, 8'h80, 8'hFF → one tx_start and 24 contiguous tx_byte cycles with bits matching. fifo_rd_en pulses at bit_cnt=6 of bytes 1 and 2. One done.
- Burst limit, MAX_BURST=2: FIFO holds 3 bytes → frame 1 carries 2 bytes, then done, IDLE, and a new frame (fresh tx_start) carries byte 3.
- FIFO runs empty: 1 byte loaded, then a second byte written at bit_cnt=6 (after the check) → frame ends after 8 bits. The second byte goes in a new frame.
- send_en drop and LSB-first: MSB_FIRST=0, data 8'h0F, send_en=0 from bit 2 → all 8 bits sent (1,1,1,1,0,0,0,0), no further pop, done.
- Reset mid-byte: reset_n=0 at bit_cnt=4 → next cycle all outputs 0, state IDLE, no done. Resumes from the next FIFO word when reset_n=1.
